hd_secded_pkt_rx: RTL and testbench
===================================

Name: hd_secded_pkt_rx

Overview:
Parametrised successor to the 16-bit Hamming packet receiver. It receives SECDED-encoded code words framed by sop/eop and corrects single-bit errors per word. Double-bit errors cause the whole packet to be discarded with a retransmit request. Clean packets are buffered store-and-forward, the priority field is extracted from word 0, and corrected words are drained downstream over a valid/ready stream; saturating statistics counters are kept for monitoring.

Parameters:
CODE_WIDTH, 16, code word width; power of 2, ≥8; bit 0 = overall parity, bits at positions 2^i = check bits
MAX_WORDS, 64, packet buffer depth in words; ≥2
PRIORITY_BIT, 3, priority field width
PRIO_LSB, 8, LSB position of the priority field inside corrected word 0; PRIO_LSB+PRIORITY_BIT ≤ CODE_WIDTH
CNT_WIDTH, 16, statistics counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
wr_sop  in  1  first word of packet; qualified by wr_vld
wr_eop  in  1  last word of packet; qualified by wr_vld
wr_vld  in  1  input word valid; no backpressure
wr_data  in  CODE_WIDTH  encoded input word
in_busy  out  1  high while buffer holds an unsent packet (SEND)
rd_sop  out  1  first output word
rd_eop  out  1  last output word
rd_vld  out  1  output word valid
rd_ready  in  1  downstream accepts word
rd_data  out  CODE_WIDTH  corrected code word
pkt_len  out  clog2(MAX_WORDS+1)  word count of packet in SEND
prior  out  PRIORITY_BIT  priority of the current/last accepted packet
error  out  1  one-cycle pulse: packet dropped, retransmit requested
corr_cnt  out  CNT_WIDTH  words with a corrected single-bit error
err_cnt  out  CNT_WIDTH  packets dropped (double error, overflow, abort, busy)

Behaviour:
- Reset: all outputs 0, all counters 0, FSM to IDLE, buffer contents don't-care.
- Decode (combinational, per word): s = XOR of indices i (1..CODE_WIDTH-1) with bit i set; p = XOR of all bits.
  - s=0, p=0: clean word.
  - p=1: single error; flip bit s (s=0 flips bit 0); corr_cnt +1.
  - s≠0, p=0: double error.
- FSM IDLE: wr_vld&wr_sop → write corrected word 0, set wcnt=1, go to RECV, or to CHECK if wr_eop is also high. Words without sop in IDLE are ignored.
- FSM RECV: each wr_vld writes the word at wcnt and increments wcnt.
  - A double error, or a word when wcnt=MAX_WORDS, sets a sticky drop flag; the word is not written.
  - A word with wr_eop → CHECK.
  - A word with wr_sop (abort) → count 1 drop, pulse error, restart reception with this word as word 0.
- FSM CHECK (1 cycle): if the drop flag is clear → SEND, latch pkt_len=wcnt, update prior. Otherwise → IDLE, pulse error, err_cnt +1.
- prior: prior = corrected word0[PRIO_LSB+PRIORITY_BIT-1:PRIO_LSB]. It updates only on a clean packet and holds otherwise.
- FSM SEND: in_busy=1, rd_vld=1, rd_data=buf[rptr].
  - rd_sop=(rptr==0), rd_eop=(rptr==pkt_len-1).
  - rptr advances on rd_vld&rd_ready.
  - The transfer with rd_eop → IDLE next cycle; rptr clears.
  - rd_data/sop/eop stay stable while rd_vld&!rd_ready.
- Busy drop: any wr_vld&wr_sop seen in CHECK or SEND → error pulse, err_cnt +1. That packet's remaining words are ignored until its eop; no data corruption.
- Latency: eop word at cycle T → rd_vld at T+2 (CHECK at T+1) or error at T+1.
- Counters saturate at all-ones. corr_cnt counts words in dropped packets too.
- Simultaneous corr and drop events in one cycle: both counters update.
- rst mid-packet or mid-SEND: everything is discarded; outputs return to reset values next cycle.

Test Plan:
- Clean 4-word packet, word0=0x0700-encoded (prior field=3'b111), rd_ready=1 → rd_vld at eop+2 for 4 cycles, sop on 1st, eop on 4th, prior=7, pkt_len=4, error never.
- Flip bit 5 of word 2 → corrected output identical to clean case, corr_cnt=1, err_cnt=0.
- Flip bits 3 and 9 of word 1 → no rd_vld, error pulse 1 cycle at eop+1, err_cnt=1, prior unchanged.
- MAX_WORDS+1-word packet → dropped, error pulse, err_cnt=1; a following 1-word sop&eop packet is delivered with rd_sop=rd_eop=1, pkt_len=1.
- Backpressure: rd_ready toggles 1,0,0,1… during SEND → rd_data held stable during stalls, every word delivered once; a new sop during SEND → error pulse, that packet is never output.
- Assert rst during RECV and again during SEND → next cycle all outputs are 0 and FSM is IDLE; a subsequent clean packet is delivered normally.

Source files
------------

// File: rtl/hd_secded_pkt_rx.sv
// hd_secded_pkt_rx - SECDED packet receiver with store-and-forward buffer.
//
// Incoming code words (bit 0 = overall parity, bits 2^i = check bits) are
// decoded on the fly. Single-bit errors are corrected before buffering.
// A packet containing a double-bit error, more than MAX_WORDS words, an
// abort (sop inside a packet) or arriving while the buffer is busy is
// dropped with a one-cycle error pulse. Clean packets are replayed over a
// valid/ready stream.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   wr_vld/sop/eop/data input word stream (no backpressure)
//   in_busy             buffer holds a packet being sent
//   rd_vld/sop/eop/data output stream, rd_ready from downstream
//   pkt_len             word count of the packet being sent
//   prior               priority field of the last clean packet
//   error               one-cycle pulse per dropped packet
//   corr_cnt, err_cnt   saturating corrected-word / dropped-packet counters
module hd_secded_pkt_rx #(
    parameter int CODE_WIDTH   = 16,
    parameter int MAX_WORDS    = 64,
    parameter int PRIORITY_BIT = 3,
    parameter int PRIO_LSB     = 8,
    parameter int CNT_WIDTH    = 16,
    localparam int LEN_W       = $clog2(MAX_WORDS + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_sop,
    input  logic                    wr_eop,
    input  logic                    wr_vld,
    input  logic [CODE_WIDTH-1:0]   wr_data,
    output logic                    in_busy,
    output logic                    rd_sop,
    output logic                    rd_eop,
    output logic                    rd_vld,
    input  logic                    rd_ready,
    output logic [CODE_WIDTH-1:0]   rd_data,
    output logic [LEN_W-1:0]        pkt_len,
    output logic [PRIORITY_BIT-1:0] prior,
    output logic                    error,
    output logic [CNT_WIDTH-1:0]    corr_cnt,
    output logic [CNT_WIDTH-1:0]    err_cnt
);

    localparam int SW = $clog2(CODE_WIDTH);
    localparam int AW = $clog2(MAX_WORDS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RECV  = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_SEND  = 2'd3;

    logic [1:0]              state;
    logic [LEN_W-1:0]        wcnt;
    logic [LEN_W-1:0]        rptr;
    logic                    drop;
    logic [PRIORITY_BIT-1:0] w0_prio;
    logic [CODE_WIDTH-1:0]   mem [MAX_WORDS];

    // ---------------- decoder ----------------
    logic [SW-1:0]         syn;
    logic                  par;
    logic [CODE_WIDTH-1:0] corr_word;
    logic                  dbl;

    always_comb begin
        syn = '0;
        par = ^wr_data;
        for (int i = 1; i < CODE_WIDTH; i++)
            if (wr_data[i]) syn ^= SW'(i);
        // syn == 0 with odd parity means the parity bit itself flipped
        corr_word = wr_data;
        if (par) corr_word[syn] = ~wr_data[syn];
    end

    assign dbl = (syn != '0) && !par;

    // ---------------- control ----------------
    logic send, in_recv, abort, start, busy_drop, check_fail, full, wr_word;
    logic corr_inc;
    logic [1:0] err_inc;

    assign send       = (state == S_SEND);
    assign in_recv    = (state == S_RECV) && wr_vld;
    assign abort      = in_recv && wr_sop;
    // word 0 is taken from IDLE or as the restart word of an aborted packet
    assign start      = ((state == S_IDLE) && wr_vld && wr_sop) || abort;
    assign busy_drop  = ((state == S_CHECK) || send) && wr_vld && wr_sop;
    assign check_fail = (state == S_CHECK) && drop;
    assign full       = (wcnt == LEN_W'(MAX_WORDS));
    assign wr_word    = in_recv && !wr_sop && !dbl && !full;
    assign corr_inc   = (start || in_recv) && par;
    assign err_inc    = {1'b0, abort} + {1'b0, busy_drop} + {1'b0, check_fail};

    assign error   = abort || busy_drop || check_fail;
    assign in_busy = send;
    assign rd_vld  = send;
    assign rd_sop  = send && (rptr == '0);
    assign rd_eop  = send && (rptr == pkt_len - LEN_W'(1));
    assign rd_data = send ? mem[rptr[AW-1:0]] : '0;

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] c,
                                                     input logic [1:0] inc);
        logic [CNT_WIDTH:0] s;
        s = {1'b0, c} + {{(CNT_WIDTH-1){1'b0}}, inc};
        return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
    endfunction

    // buffer storage carries no reset; contents are only read in SEND
    always_ff @(posedge clk) begin
        if (start)
            mem[0] <= corr_word;
        else if (wr_word)
            mem[wcnt[AW-1:0]] <= corr_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            wcnt     <= '0;
            rptr     <= '0;
            drop     <= 1'b0;
            w0_prio  <= '0;
            pkt_len  <= '0;
            prior    <= '0;
            corr_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            corr_cnt <= sat_add(corr_cnt, {1'b0, corr_inc});
            err_cnt  <= sat_add(err_cnt, err_inc);
            case (state)
                S_IDLE, S_RECV: begin
                    if (start) begin
                        wcnt    <= LEN_W'(1);
                        drop    <= dbl;
                        w0_prio <= corr_word[PRIO_LSB +: PRIORITY_BIT];
                        state   <= wr_eop ? S_CHECK : S_RECV;
                    end else if (in_recv) begin
                        if (wr_word) wcnt <= wcnt + LEN_W'(1);
                        // drop is sticky until the next word 0
                        if (dbl || full) drop <= 1'b1;
                        if (wr_eop) state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    rptr <= '0;
                    if (drop) begin
                        state <= S_IDLE;
                    end else begin
                        state   <= S_SEND;
                        pkt_len <= wcnt;
                        prior   <= w0_prio;
                    end
                end
                default: begin
                    if (rd_ready) begin
                        if (rd_eop) begin
                            state <= S_IDLE;
                            rptr  <= '0;
                        end else begin
                            rptr <= rptr + LEN_W'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hd_secded_pkt_rx.sv
// Self-checking bench for hd_secded_pkt_rx: directed cases then random
// packets, compared against a packet-level reference model.
module tb_hd_secded_pkt_rx;

    localparam int CW   = 16;
    localparam int MW   = 8;
    localparam int PB   = 3;
    localparam int PL   = 8;
    localparam int CNTW = 4;
    localparam int LW   = $clog2(MW + 1);
    localparam int CMAX = (1 << CNTW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_sop = 1'b0, wr_eop = 1'b0, wr_vld = 1'b0;
    logic [CW-1:0] wr_data = '0;
    logic          rd_ready = 1'b1;
    logic          in_busy, rd_sop, rd_eop, rd_vld, error;
    logic [CW-1:0] rd_data;
    logic [LW-1:0] pkt_len;
    logic [PB-1:0] prior;
    logic [CNTW-1:0] corr_cnt, err_cnt;

    hd_secded_pkt_rx #(.CODE_WIDTH(CW), .MAX_WORDS(MW), .PRIORITY_BIT(PB),
                       .PRIO_LSB(PL), .CNT_WIDTH(CNTW)) dut (
        .clk(clk), .rst(rst), .wr_sop(wr_sop), .wr_eop(wr_eop), .wr_vld(wr_vld),
        .wr_data(wr_data), .in_busy(in_busy), .rd_sop(rd_sop), .rd_eop(rd_eop),
        .rd_vld(rd_vld), .rd_ready(rd_ready), .rd_data(rd_data), .pkt_len(pkt_len),
        .prior(prior), .error(error), .corr_cnt(corr_cnt), .err_cnt(err_cnt));

    always #5 clk = ~clk;

    int ncmp = 0, nfail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // reference model state
    int            m_corr = 0, m_err = 0;
    logic [PB-1:0] m_prior = '0;

    function automatic int sat(input int x);
        return (x > CMAX) ? CMAX : x;
    endfunction

    // encoder: check bits take the XOR of the set data-bit indices, so the
    // resulting word XORs to index 0; bit 0 then makes overall parity even
    function automatic logic [CW-1:0] enc(input logic [CW-1:0] r);
        logic [CW-1:0] w;
        logic [3:0]    s;
        w = r;
        w[0] = 1'b0;
        for (int k = 0; k < 4; k++) w[1 << k] = 1'b0;
        s = '0;
        for (int i = 1; i < CW; i++) if (w[i]) s ^= 4'(i);
        for (int k = 0; k < 4; k++) w[1 << k] = s[k];
        w[0] = ^w;
        return w;
    endfunction

    // output monitor
    logic [CW-1:0] outq[$];
    bit            sopq[$], eopq[$];
    int            err_pulses = 0;
    logic          pv = 1'b0, pr = 1'b0, ps = 1'b0, pe = 1'b0;
    logic [CW-1:0] pd = '0;

    always @(negedge clk) begin
        if (error === 1'b1) err_pulses++;
        if (pv && !pr && rd_vld === 1'b1) begin
            chk("stall data", 32'(rd_data), 32'(pd));
            chk("stall sop/eop", {30'd0, rd_sop, rd_eop}, {30'd0, ps, pe});
        end
        if (rd_vld === 1'b1 && rd_ready === 1'b1) begin
            outq.push_back(rd_data);
            sopq.push_back(rd_sop);
            eopq.push_back(rd_eop);
        end
        pv = rd_vld; pr = rd_ready; pd = rd_data; ps = rd_sop; pe = rd_eop;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_pkt(input logic [CW-1:0] tx[$]);
        for (int i = 0; i < tx.size(); i++) begin
            @(posedge clk); #1;
            wr_vld = 1'b1; wr_sop = (i == 0); wr_eop = (i == tx.size() - 1); wr_data = tx[i];
        end
        @(posedge clk); #1;
        wr_vld = 1'b0; wr_sop = 1'b0; wr_eop = 1'b0; wr_data = '0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " outputs"}, {4'd0, rd_vld, rd_sop, rd_eop, in_busy, error, rd_data, pkt_len, prior}, 32'd0);
        chk({tag, " counters"}, {24'd0, corr_cnt, err_cnt}, 32'd0);
    endtask

    // bp: 0 always ready, 1 pattern 1,0,0,1, 2 random
    task automatic run_pkt(input string tag, input logic [CW-1:0] clean[$], input logic [CW-1:0] tx[$],
                           input int nsingle, input bit dbl, input int bp);
        int  len, c;
        bit  drop;
        len  = clean.size();
        drop = dbl || (len > MW);
        outq.delete(); sopq.delete(); eopq.delete();
        err_pulses = 0;
        drive_pkt(tx);
        @(negedge clk);
        chk({tag, " error@eop+1"}, 32'(error), 32'(drop));
        chk({tag, " vld@eop+1"}, 32'(rd_vld), 32'd0);
        m_corr = sat(m_corr + nsingle);
        if (drop) m_err = sat(m_err + 1);
        else      m_prior = clean[0][PL +: PB];
        @(negedge clk);
        chk({tag, " error@eop+2"}, 32'(error), 32'd0);
        chk({tag, " vld@eop+2"}, 32'(rd_vld), 32'(!drop));
        chk({tag, " corr_cnt"}, 32'(corr_cnt), 32'(m_corr));
        chk({tag, " err_cnt"}, 32'(err_cnt), 32'(m_err));
        chk({tag, " prior"}, 32'(prior), 32'(m_prior));
        if (!drop) begin
            chk({tag, " pkt_len"}, 32'(pkt_len), 32'(len));
            c = 0;
            while (outq.size() < len && c < 200) begin
                @(posedge clk); #1;
                case (bp)
                    0:       rd_ready = 1'b1;
                    1:       rd_ready = ((c % 4) == 0) || ((c % 4) == 3);
                    default: rd_ready = 1'($urandom_range(0, 1));
                endcase
                c++;
            end
            rd_ready = 1'b1;
            chk({tag, " word count"}, 32'(outq.size()), 32'(len));
            for (int k = 0; k < outq.size() && k < len; k++) begin
                chk({tag, " data"}, 32'(outq[k]), 32'(clean[k]));
                chk({tag, " sop/eop"}, {30'd0, sopq[k], eopq[k]}, {30'd0, k == 0, k == len - 1});
            end
            @(negedge clk);
            chk({tag, " idle after"}, {30'd0, rd_vld, in_busy}, 32'd0);
        end
        chk({tag, " error pulses"}, 32'(err_pulses), 32'(drop));
    endtask

    initial begin
        logic [CW-1:0] a[$], t[$], b[$];
        int ns, len, di, b1, b2;
        bit dbl;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1 rst = 1'b0;

        // clean 4-word packet, word 0 carries priority 3'b111
        a = {enc(16'h0F00), enc(16'h1234), enc(16'hA5A0), enc(16'h0C30)};
        run_pkt("clean4", a, a, 0, 1'b0, 0);

        // single-bit error in word 2
        t = a; t[2] ^= 16'h0020;
        run_pkt("single", a, t, 1, 1'b0, 0);

        // double error in word 1; priority must hold
        b = {enc(16'h0200), enc(16'h4440), enc(16'h8880)};
        t = b; t[1] ^= 16'h0208;
        run_pkt("double", b, t, 0, 1'b1, 0);

        // overflow by one word, then a single-word packet
        b = {};
        for (int i = 0; i <= MW; i++) b.push_back(enc(16'($urandom)));
        run_pkt("overflow", b, b, 0, 1'b0, 0);
        b = {enc(16'h0500)};
        run_pkt("oneword", b, b, 0, 1'b0, 0);

        // backpressure pattern
        run_pkt("bp", a, a, 0, 1'b0, 1);

        // new sop while sending is dropped and never output
        outq.delete(); sopq.delete(); eopq.delete();
        err_pulses = 0;
        rd_ready = 1'b0;
        b = {enc(16'h0300), enc(16'h7770), enc(16'h1110)};
        drive_pkt(b);
        m_prior = b[0][PL +: PB];
        @(negedge clk);
        @(negedge clk);
        chk("busy send vld", 32'(rd_vld), 32'd1);
        t = {enc(16'h0600), enc(16'h2220), enc(16'h3330)};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            wr_vld = 1'b1; wr_sop = (i == 0); wr_eop = (i == 2); wr_data = t[i];
            if (i == 0) begin
                @(negedge clk);
                chk("busy error", 32'(error), 32'd1);
            end
        end
        @(posedge clk); #1;
        wr_vld = 1'b0; wr_sop = 1'b0; wr_eop = 1'b0;
        m_err = sat(m_err + 1);
        rd_ready = 1'b1;
        repeat (12) @(negedge clk);
        chk("busy words", 32'(outq.size()), 32'd3);
        for (int k = 0; k < outq.size() && k < 3; k++) chk("busy data", 32'(outq[k]), 32'(b[k]));
        chk("busy pulses", 32'(err_pulses), 32'd1);
        chk("busy err_cnt", 32'(err_cnt), 32'(m_err));
        chk("busy prior", 32'(prior), 32'(m_prior));

        // reset during RECV (word 1 carries a correctable error)
        @(posedge clk); #1;
        wr_vld = 1'b1; wr_sop = 1'b1; wr_data = a[0];
        @(posedge clk); #1;
        wr_sop = 1'b0; wr_data = a[1] ^ 16'h0010;
        @(posedge clk); #1;
        wr_vld = 1'b0; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_zero("rst recv");
        m_corr = 0; m_err = 0; m_prior = '0;
        run_pkt("after rst recv", a, a, 0, 1'b0, 0);

        // reset during SEND
        rd_ready = 1'b0;
        drive_pkt(a);
        @(negedge clk);
        @(negedge clk);
        chk("rst send vld", 32'(rd_vld), 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_zero("rst send");
        rd_ready = 1'b1;
        m_corr = 0; m_err = 0; m_prior = '0;
        run_pkt("after rst send", a, a, 0, 1'b0, 0);

        // random packets
        for (int p = 0; p < 30; p++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
                wr_vld = 1'b1; wr_sop = 1'b0; wr_eop = 1'($urandom_range(0, 1));
                wr_data = 16'($urandom);
            end
            @(posedge clk); #1;
            wr_vld = 1'b0; wr_eop = 1'b0;
            len = ($urandom_range(0, 7) == 0) ? MW + 1 : $urandom_range(1, MW);
            dbl = ($urandom_range(0, 5) == 0);
            di  = $urandom_range(0, len - 1);
            a = {}; t = {}; ns = 0;
            for (int i = 0; i < len; i++) begin
                a.push_back(enc(16'($urandom)));
                t.push_back(a[i]);
                if (dbl && i == di) begin
                    b1 = $urandom_range(0, CW - 1);
                    b2 = (b1 + $urandom_range(1, CW - 1)) % CW;
                    t[i] ^= (16'(1) << b1) | (16'(1) << b2);
                end else if ($urandom_range(0, 3) == 0) begin
                    t[i] ^= 16'(1) << $urandom_range(0, CW - 1);
                    ns++;
                end
            end
            run_pkt("random", a, t, ns, dbl, $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
